// File: rtl/bat_input_pkg.sv
// ------------------------------------------------------------------------
// bat_input_pkg: shared constants and quadrature decode helper. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package bat_input_pkg;

  localparam int MOVE_W       = 9;
  localparam int ACC_W        = 10;
  localparam int ACC_MAX      = 255;
  localparam int ACC_MIN      = -255;
  localparam int PRIME_CYCLES = 3;
  localparam int PRIME_W      = 2;

  // Bit {prev,cur} set when that {a,b} pair is a legal transition in the given direction.
  localparam logic [15:0] Q_FWD = 16'h2814;
  localparam logic [15:0] Q_REV = 16'h4182;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2
  } step_e;

  function automatic step_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [3:0] idx;
    idx = {prev, cur};
    if (Q_FWD[idx]) begin
      return STEP_FWD;
    end
    if (Q_REV[idx]) begin
      return STEP_REV;
    end
    return STEP_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_channel.sv
// ------------------------------------------------------------------------
// quad_channel: one paddle's quadrature decode, frame delta and idle detect. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module quad_channel
  import bat_input_pkg::*;
#(
  parameter int STEP_SHIFT  = 1,
  parameter int IDLE_FRAMES = 600,
  parameter int IDLE_W      = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vs_rise_i,
  input  logic              qa_i,
  input  logic              qb_i,
  output logic [MOVE_W-1:0] move_o,
  output logic              human_o
);

  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] DELTA     = SUM_W'(1 << STEP_SHIFT);
  localparam logic signed [SUM_W-1:0] SAT_HI    = SUM_W'(ACC_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO    = SUM_W'(ACC_MIN);
  localparam logic [IDLE_W-1:0]       IDLE_LAST = IDLE_W'(IDLE_FRAMES - 1);
  localparam logic [PRIME_W-1:0]      PRIME_END = PRIME_W'(PRIME_CYCLES);

  logic [1:0]              sync1_q, sync2_q, prev_q;
  logic [PRIME_W-1:0]      prime_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [MOVE_W-1:0]       move_q, move_d;
  logic                    human_q, human_d;
  logic                    active_q, active_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;

  logic                    primed;
  logic                    moved;
  step_e                   step;
  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sat;

  always_comb begin
    primed = (prime_q == PRIME_END);
    step   = primed ? quad_decode(prev_q, sync2_q) : STEP_NONE;
    moved  = (step != STEP_NONE);
    case (step)
      STEP_FWD: delta = DELTA;
      STEP_REV: delta = -DELTA;
      default:  delta = '0;
    endcase

    sum = SUM_W'(acc_q) + delta;
    if (sum > SAT_HI) begin
      sat = SAT_HI;
    end else if (sum < SAT_LO) begin
      sat = SAT_LO;
    end else begin
      sat = sum;
    end

    // A step decoded on the frame edge starts the next frame instead of being dropped.
    acc_d = vs_rise_i ? delta[ACC_W-1:0] : sat[ACC_W-1:0];
  end

  always_comb begin
    move_d   = move_q;
    human_d  = human_q;
    idle_d   = idle_q;
    active_d = active_q;
    if (vs_rise_i) begin
      move_d   = acc_q[MOVE_W-1:0];
      active_d = 1'b0;
      if (active_q || moved) begin
        idle_d  = '0;
        human_d = 1'b1;
      end else if (idle_q == IDLE_LAST) begin
        human_d = 1'b0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else if (moved) begin
      active_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      prime_q  <= '0;
      acc_q    <= '0;
      move_q   <= '0;
      human_q  <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= '0;
    end else begin
      sync1_q  <= {qa_i, qb_i};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      if (!primed) begin
        prime_q <= prime_q + 1'b1;
      end
      acc_q    <= acc_d;
      move_q   <= move_d;
      human_q  <= human_d;
      active_q <= active_d;
      idle_q   <= idle_d;
    end
  end

  assign move_o  = move_q;
  assign human_o = human_q;

endmodule

`default_nettype wire

// File: rtl/bat_quad_input.sv
// ------------------------------------------------------------------------
// bat_quad_input: two-paddle quadrature front end with frame-edge latching. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module bat_quad_input
  import bat_input_pkg::*;
#(
  parameter int STEP_SHIFT  = 1,
  parameter int IDLE_FRAMES = 600,
  parameter int IDLE_W      = 10
) (
  input  logic              glb_clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              l_qa,
  input  logic              l_qb,
  input  logic              r_qa,
  input  logic              r_qb,
  output logic [MOVE_W-1:0] lbat_move,
  output logic              lbat_human,
  output logic [MOVE_W-1:0] rbat_move,
  output logic              rbat_human
);

  logic vsync_q;
  logic vs_rise;

  always_ff @(posedge glb_clk) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  // vsync is active-low, so its rising edge marks the end of the blanking pulse.
  assign vs_rise = vsync & ~vsync_q;

  quad_channel #(
    .STEP_SHIFT (STEP_SHIFT),
    .IDLE_FRAMES(IDLE_FRAMES),
    .IDLE_W     (IDLE_W)
  ) u_left (
    .clk_i    (glb_clk),
    .rst_ni   (reset_n),
    .vs_rise_i(vs_rise),
    .qa_i     (l_qa),
    .qb_i     (l_qb),
    .move_o   (lbat_move),
    .human_o  (lbat_human)
  );

  quad_channel #(
    .STEP_SHIFT (STEP_SHIFT),
    .IDLE_FRAMES(IDLE_FRAMES),
    .IDLE_W     (IDLE_W)
  ) u_right (
    .clk_i    (glb_clk),
    .rst_ni   (reset_n),
    .vs_rise_i(vs_rise),
    .qa_i     (r_qa),
    .qb_i     (r_qb),
    .move_o   (rbat_move),
    .human_o  (rbat_human)
  );

endmodule

`default_nettype wire

// File: tb/tb_bat_quad_input.sv
// ------------------------------------------------------------------------
// tb_bat_quad_input: directed stimulus with a per-cycle behavioural model. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_bat_quad_input;

  localparam int STEP    = 2;
  localparam int IDLE_FR = 600;

  logic       clk = 1'b0;
  logic       rst_n, vsync, l_qa, l_qb, r_qa, r_qb;
  logic [8:0] lbat_move, rbat_move;
  logic       lbat_human, rbat_human;

  int checks = 0;
  int failures = 0;
  int lpos, rpos;

  always #5 clk = ~clk;

  bat_quad_input dut (
    .glb_clk   (clk),
    .reset_n   (rst_n),
    .vsync     (vsync),
    .l_qa      (l_qa),
    .l_qb      (l_qb),
    .r_qa      (r_qa),
    .r_qb      (r_qb),
    .lbat_move (lbat_move),
    .lbat_human(lbat_human),
    .rbat_move (rbat_move),
    .rbat_human(rbat_human)
  );

  // Paddle position around the Gray cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] enc(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int pos_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v > 255) return 255;
    if (v < -255) return -255;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pins seen by the decoder two edges late, counted as position differences.
  logic [1:0] m_hist [2][3];
  logic [1:0] m_pins [2];
  int         m_since, m_acc[2], m_move[2], m_quiet[2];
  bit         m_seen[2], m_active[2], m_vsd, m_valid = 1'b0;

  always @(posedge clk) begin
    m_pins[0] = {l_qa, l_qb};
    m_pins[1] = {r_qa, r_qb};
    if (!rst_n) begin
      m_valid = 1'b1;
      m_since = 0;
      m_vsd   = 1'b0;
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 3; k++) m_hist[c][k] = 2'b00;
        m_acc[c] = 0; m_move[c] = 0; m_quiet[c] = 0;
        m_seen[c] = 1'b0; m_active[c] = 1'b0;
      end
    end else begin
      bit vr;
      vr = vsync && !m_vsd;
      m_vsd = vsync;
      for (int c = 0; c < 2; c++) begin
        int stp, diff;
        stp = 0;
        if (m_since >= 3) begin
          diff = (pos_of(m_hist[c][1]) - pos_of(m_hist[c][2]) + 4) % 4;
          stp = (diff == 1) ? 1 : (diff == 3) ? -1 : 0;
        end
        if (vr) begin
          m_move[c] = m_acc[c];
          m_acc[c]  = stp * STEP;
          if (m_active[c] || stp != 0) begin
            m_seen[c] = 1'b1;
            m_quiet[c] = 0;
          end else if (m_quiet[c] < 100000) begin
            m_quiet[c]++;
          end
          m_active[c] = 1'b0;
        end else begin
          m_acc[c] = clamp(m_acc[c] + stp * STEP);
          if (stp != 0) m_active[c] = 1'b1;
        end
        m_hist[c][2] = m_hist[c][1];
        m_hist[c][1] = m_hist[c][0];
        m_hist[c][0] = m_pins[c];
      end
      if (m_since < 3) m_since++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [8:0] el, er;
      el = 9'(m_move[0]);
      er = 9'(m_move[1]);
      chk("model_lbat_move", 32'(lbat_move), 32'(el));
      chk("model_rbat_move", 32'(rbat_move), 32'(er));
      chk("model_lbat_human", 32'(lbat_human), 32'(m_seen[0] && m_quiet[0] < IDLE_FR));
      chk("model_rbat_human", 32'(rbat_human), 32'(m_seen[1] && m_quiet[1] < IDLE_FR));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lstep(input int dir);
    lpos = (lpos + dir + 4) % 4;
    {l_qa, l_qb} = enc(lpos);
    @(negedge clk);
  endtask

  task automatic rstep(input int dir);
    rpos = (rpos + dir + 4) % 4;
    {r_qa, r_qb} = enc(rpos);
    @(negedge clk);
  endtask

  // Low pulse on vsync; the frame edge lands on the posedge just before return.
  task automatic pulse();
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1;
    lpos = 2; rpos = 2;
    {l_qa, l_qb} = enc(lpos);
    {r_qa, r_qb} = enc(rpos);
    @(negedge clk);
    cyc(10);
    chk("reset_lmove", 32'(lbat_move), 32'd0);
    chk("reset_lhuman", 32'(lbat_human), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    repeat (3) pulse();
    chk("rest_lmove", 32'(lbat_move), 32'd0);
    chk("rest_rmove", 32'(rbat_move), 32'd0);
    chk("rest_lhuman", 32'(lbat_human), 32'd0);
    chk("rest_rhuman", 32'(rbat_human), 32'd0);

    repeat (20) lstep(1);
    cyc(4);
    pulse();
    chk("fwd_lmove", 32'(lbat_move), 32'd40);
    chk("fwd_lhuman", 32'(lbat_human), 32'd1);
    chk("fwd_rmove", 32'(rbat_move), 32'd0);
    chk("fwd_rhuman", 32'(rbat_human), 32'd0);
    pulse();
    chk("still_lmove", 32'(lbat_move), 32'd0);

    repeat (10) rstep(-1);
    cyc(4);
    pulse();
    chk("rev_rmove", 32'(rbat_move), 32'h1EC);
    repeat (200) rstep(1);
    cyc(4);
    pulse();
    chk("sat_rmove", 32'(rbat_move), 32'd255);

    lstep(1);
    pulse();
    chk("edge_excl_lmove", 32'(lbat_move), 32'd0);
    cyc(4);
    pulse();
    chk("edge_next_lmove", 32'(lbat_move), 32'd2);

    while (lpos != 0) lstep(1);
    cyc(4);
    pulse();
    lpos = 2;
    {l_qa, l_qb} = enc(lpos);
    cyc(5);
    pulse();
    chk("illegal_lmove", 32'(lbat_move), 32'd0);

    lstep(1);
    cyc(4);
    pulse();
    chk("idle_start_lhuman", 32'(lbat_human), 32'd1);
    for (int k = 1; k <= IDLE_FR; k++) begin
      pulse();
      if (k == IDLE_FR - 1) chk("idle_599_lhuman", 32'(lbat_human), 32'd1);
      if (k == IDLE_FR) chk("idle_600_lhuman", 32'(lbat_human), 32'd0);
    end
    lstep(-1);
    cyc(4);
    pulse();
    chk("wake_lhuman", 32'(lbat_human), 32'd1);
    chk("wake_lmove", 32'(lbat_move), 32'h1FE);

    repeat (30) lstep(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse();
    chk("midreset_lmove", 32'(lbat_move), 32'd0);
    chk("midreset_lhuman", 32'(lbat_human), 32'd0);
    cyc(4);
    pulse();
    chk("midreset_quiet_lmove", 32'(lbat_move), 32'd0);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
